operand_shift_loader: RTL and testbench
=======================================

Name: operand_shift_loader

Overview:
- Parametrised operand register pair for the sequential multiplier datapath.
- Holds multiplicand mx and multiplier my, and shifts my right by STEP bits per step.
- Presents the current my digit to the partial-product logic.
- Tracks remaining digits so the controller can detect last step, completion and zero-multiplier early exit.
- Supports unsigned and two's-complement multiplier shifting (radix-2 / radix-4 digit consumption).

Parameters:
MX_W, 16, multiplicand width in bits
MY_W, 9, multiplier width in bits
STEP, 1, multiplier bits consumed per shift; legal values 1 or 2
(derived) NDIG = ceil(MY_W/STEP), digit count; CNT_W = $clog2(NDIG+1)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
IN_MX  input  MX_W  multiplicand load data
IN_MY  input  MY_W  multiplier load data
LOAD_MX  input  1  load mx from IN_MX
LOAD_MY  input  1  load my from IN_MY and restart digit count
SFT_MY  input  1  request one shift of my by STEP
SIGNED_MY  input  1  sampled with LOAD_MY; 1 = arithmetic shift of my
mx  output  MX_W  registered multiplicand
my  output  MY_W  registered multiplier (shifting)
MY_DIGIT  output  STEP  my[STEP-1:0], current digit (combinational from my)
MY_CNT  output  CNT_W  registered count of digits not yet consumed
MY_LAST  output  1  MY_CNT == 1
MY_DONE  output  1  MY_CNT == 0
MY_ZERO  output  1  my == 0 (early-termination hint)

Behaviour:
- Reset (RST_N low, asynchronous, independent of CLK):
  - mx=0, my=0, MY_CNT=0, internal sign flag=0.
  - Hence MY_DIGIT=0, MY_LAST=0, MY_DONE=1, MY_ZERO=1.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation aborts it; no partial state survives.
- LOAD_MX: mx<=IN_MX at the edge; 1-cycle latency. Independent of all other controls.
- LOAD_MY: at the edge, my<=IN_MY, MY_CNT<=NDIG, sign flag<=SIGNED_MY.
- Effective shift occurs when SFT_MY=1 and LOAD_MY=0 and MY_CNT!=0. On an effective shift:
  - my <= {STEP fill bits, my[MY_W-1:STEP]}.
  - Fill bit = my[MY_W-1] if the sign flag is set, else 0.
  - MY_CNT <= MY_CNT-1.
- Priority: LOAD_MY over SFT_MY. LOAD_MY and SFT_MY asserted in the same cycle give a load only, no shift.
- SFT_MY with MY_CNT==0 is ignored: my and MY_CNT hold, MY_DONE stays 1. There is no counter wrap-around.
- LOAD_MX concurrent with LOAD_MY or SFT_MY: both actions happen in the same edge.
- STEP=2 with odd MY_W:
  - NDIG=(MY_W+1)/2.
  - The final digit's upper bit is the fill bit (sign or 0), so signed radix-4 recoding sees a correct sign extension.
- MY_ZERO is independent of MY_CNT. A signed negative my never reaches zero via shifting; it saturates at all-ones.
- With no control active, all registers hold.
- Illegal STEP values (anything other than 1 or 2): elaboration-time error.
- Outputs MY_LAST, MY_DONE, MY_ZERO and MY_DIGIT are glitch-tolerant combinational decodes of registers. There is no extra latency.

Test Plan:
- Reset: drive RST_N=0 asynchronously mid-cycle after loading → mx=0, my=0, MY_CNT=0, MY_DONE=1, MY_ZERO=1 immediately, without waiting for a clock edge.
- Defaults, unsigned:
  - LOAD_MX=1 with IN_MX=16'hA5C3 and LOAD_MY=1 with IN_MY=9'h1B5 in the same cycle → mx=A5C3, my=1B5, MY_CNT=9, MY_DIGIT=1.
  - 9 SFT_MY pulses → MY_DIGIT sequence 1,0,1,0,1,1,0,1,1; MY_LAST after the 8th; MY_DONE and my=0 after the 9th.
  - A 10th SFT_MY → no change.
- Signed shift, defaults: LOAD_MY with IN_MY=9'h180 and SIGNED_MY=1, then 3 shifts → my=9'h1F0, MY_CNT=6, MY_ZERO=0. Repeating with SIGNED_MY=0 → my=9'h030.
- STEP=2, MY_W=9: LOAD_MY with IN_MY=9'h0E7 unsigned → MY_CNT=5.
  - Digit sequence 3,1,2,3,0.
  - my=0 after 5 shifts, MY_DONE=1.
- Collision: with MY_CNT=4, assert LOAD_MY and SFT_MY together with IN_MY=9'h003 → my=003, MY_CNT=9; no shift applied.
- Early exit: load IN_MY=9'h004 unsigned, shift 3 times → MY_ZERO=1 while MY_CNT=6 and MY_DONE=0.

Source files
------------

// File: rtl/operand_shift_loader.sv
// operand_shift_loader
// Operand register pair for the sequential multiplier datapath. Holds the
// multiplicand (mx) and the multiplier (my). The multiplier shifts right by
// STEP bits per step, so the partial-product logic always sees the current
// digit in my[STEP-1:0]. A digit counter lets the controller detect the last
// step, completion and a zero multiplier (early exit).
//
// Ports:
//   CLK        clock; all state updates on its rising edge
//   RST_N      asynchronous active-low reset
//   IN_MX      multiplicand load data
//   IN_MY      multiplier load data
//   LOAD_MX    load mx from IN_MX
//   LOAD_MY    load my from IN_MY and restart the digit count
//   SFT_MY     request one shift of my by STEP bits
//   SIGNED_MY  sampled with LOAD_MY; 1 selects an arithmetic shift of my
//   mx         registered multiplicand
//   my         registered, shifting multiplier
//   MY_DIGIT   current multiplier digit, my[STEP-1:0]
//   MY_CNT     count of digits not yet consumed
//   MY_LAST    MY_CNT == 1
//   MY_DONE    MY_CNT == 0
//   MY_ZERO    my == 0
module operand_shift_loader #(
  parameter int MX_W  = 16,
  parameter int MY_W  = 9,
  parameter int STEP  = 1,
  localparam int NDIG  = (MY_W + STEP - 1) / STEP,
  localparam int CNT_W = $clog2(NDIG + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [MX_W-1:0]  IN_MX,
  input  logic [MY_W-1:0]  IN_MY,
  input  logic             LOAD_MX,
  input  logic             LOAD_MY,
  input  logic             SFT_MY,
  input  logic             SIGNED_MY,
  output logic [MX_W-1:0]  mx,
  output logic [MY_W-1:0]  my,
  output logic [STEP-1:0]  MY_DIGIT,
  output logic [CNT_W-1:0] MY_CNT,
  output logic             MY_LAST,
  output logic             MY_DONE,
  output logic             MY_ZERO
);

  // Only radix-2 and radix-4 digit consumption are supported.
  if (STEP != 1 && STEP != 2) begin : g_bad_step
    $error("operand_shift_loader: STEP must be 1 or 2");
  end

  if (MY_W <= STEP) begin : g_bad_width
    $error("operand_shift_loader: MY_W must exceed STEP");
  end

  logic [MX_W-1:0]  mx_q, mx_d;
  logic [MY_W-1:0]  my_q, my_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;

  logic             fill;
  logic [MY_W-1:0]  my_shifted;
  logic             shift_en;

  // The fill bit replicates the sign when the operand was loaded as signed,
  // so with odd MY_W and STEP=2 the final digit's upper bit is a correct
  // sign extension for radix-4 recoding.
  assign fill       = sgn_q & my_q[MY_W-1];
  assign my_shifted = {{STEP{fill}}, my_q[MY_W-1:STEP]};

  // A load always wins over a shift; shifting stops once all digits are used.
  assign shift_en   = SFT_MY && !LOAD_MY && (cnt_q != '0);

  always_comb begin
    mx_d  = mx_q;
    my_d  = my_q;
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    if (LOAD_MX) begin
      mx_d = IN_MX;
    end
    if (LOAD_MY) begin
      my_d  = IN_MY;
      cnt_d = CNT_W'(NDIG);
      sgn_d = SIGNED_MY;
    end else if (shift_en) begin
      my_d  = my_shifted;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mx_q  <= '0;
      my_q  <= '0;
      cnt_q <= '0;
      sgn_q <= 1'b0;
    end else begin
      mx_q  <= mx_d;
      my_q  <= my_d;
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
    end
  end

  assign mx       = mx_q;
  assign my       = my_q;
  assign MY_CNT   = cnt_q;
  assign MY_DIGIT = my_q[STEP-1:0];
  assign MY_LAST  = (cnt_q == CNT_W'(1));
  assign MY_DONE  = (cnt_q == '0);
  assign MY_ZERO  = (my_q == '0);

endmodule

// File: tb/tb_operand_shift_loader.sv
// tb_operand_shift_loader
// Drives a radix-2 (STEP=1) and a radix-4 (STEP=2) instance of
// operand_shift_loader from the same control inputs. A behavioural model
// predicts the register contents; each predicted state is queued when the
// stimulus is driven and popped for comparison after the clock edge.
module tb_operand_shift_loader;

  localparam int MX_W = 16;
  localparam int MY_W = 9;

  logic            CLK;
  logic            RST_N;
  logic [MX_W-1:0] IN_MX;
  logic [MY_W-1:0] IN_MY;
  logic            LOAD_MX, LOAD_MY, SFT_MY, SIGNED_MY;

  logic [MX_W-1:0] mx1, mx2;
  logic [MY_W-1:0] my1, my2;
  logic [0:0]      dig1;
  logic [1:0]      dig2;
  logic [3:0]      cnt1;
  logic [2:0]      cnt2;
  logic            last1, done1, zero1, last2, done2, zero2;

  operand_shift_loader #(.MX_W(MX_W), .MY_W(MY_W), .STEP(1)) u_r2 (
    .CLK(CLK), .RST_N(RST_N), .IN_MX(IN_MX), .IN_MY(IN_MY),
    .LOAD_MX(LOAD_MX), .LOAD_MY(LOAD_MY), .SFT_MY(SFT_MY), .SIGNED_MY(SIGNED_MY),
    .mx(mx1), .my(my1), .MY_DIGIT(dig1), .MY_CNT(cnt1),
    .MY_LAST(last1), .MY_DONE(done1), .MY_ZERO(zero1)
  );

  operand_shift_loader #(.MX_W(MX_W), .MY_W(MY_W), .STEP(2)) u_r4 (
    .CLK(CLK), .RST_N(RST_N), .IN_MX(IN_MX), .IN_MY(IN_MY),
    .LOAD_MX(LOAD_MX), .LOAD_MY(LOAD_MY), .SFT_MY(SFT_MY), .SIGNED_MY(SIGNED_MY),
    .mx(mx2), .my(my2), .MY_DIGIT(dig2), .MY_CNT(cnt2),
    .MY_LAST(last2), .MY_DONE(done2), .MY_ZERO(zero2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [MX_W-1:0] mx;
    logic [MY_W-1:0] my1;
    int              cnt1;
    logic [MY_W-1:0] my2;
    int              cnt2;
  } expect_t;

  expect_t scoreQ[$];

  int checks = 0;
  int errors = 0;

  // Model state for both instances.
  logic [MX_W-1:0] mxM;
  logic [MY_W-1:0] my1M, my2M;
  int              cnt1M, cnt2M;
  logic            sg1M, sg2M;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shifts one bit at a time; repeated single-bit arithmetic shifts define
  // the expected multi-bit result.
  function automatic logic [MY_W-1:0] modelShift(input logic [MY_W-1:0] v, input logic sgn, input int n);
    logic [MY_W-1:0] r;
    r = v;
    for (int k = 0; k < n; k++) begin
      r = {sgn & r[MY_W-1], r[MY_W-1:1]};
    end
    return r;
  endfunction

  task automatic modelReset();
    mxM = '0; my1M = '0; my2M = '0;
    cnt1M = 0; cnt2M = 0; sg1M = 1'b0; sg2M = 1'b0;
  endtask

  // Compares every output of both instances against one expected state.
  task automatic compareAll(input expect_t e);
    checkOutput("mx1", 32'(mx1), 32'(e.mx));
    checkOutput("mx2", 32'(mx2), 32'(e.mx));
    checkOutput("my1", 32'(my1), 32'(e.my1));
    checkOutput("cnt1", 32'(cnt1), 32'(e.cnt1));
    checkOutput("dig1", 32'(dig1), 32'(e.my1[0]));
    checkOutput("last1", 32'(last1), 32'(e.cnt1 == 1));
    checkOutput("done1", 32'(done1), 32'(e.cnt1 == 0));
    checkOutput("zero1", 32'(zero1), 32'(e.my1 == 0));
    checkOutput("my2", 32'(my2), 32'(e.my2));
    checkOutput("cnt2", 32'(cnt2), 32'(e.cnt2));
    checkOutput("dig2", 32'(dig2), 32'(e.my2 & 9'h3));
    checkOutput("last2", 32'(last2), 32'(e.cnt2 == 1));
    checkOutput("done2", 32'(done2), 32'(e.cnt2 == 0));
    checkOutput("zero2", 32'(zero2), 32'(e.my2 == 0));
  endtask

  // Drives one cycle of controls, queues the predicted state and compares
  // it against the registers once the edge has passed.
  task automatic applyStimulus(input logic lmx, input logic [MX_W-1:0] inMx,
                               input logic lmy, input logic [MY_W-1:0] inMy,
                               input logic sgn, input logic sft);
    expect_t e;
    @(negedge CLK);
    LOAD_MX = lmx; IN_MX = inMx; LOAD_MY = lmy; IN_MY = inMy;
    SIGNED_MY = sgn; SFT_MY = sft;
    if (lmx) mxM = inMx;
    if (lmy) begin
      my1M = inMy; cnt1M = 9; sg1M = sgn;
      my2M = inMy; cnt2M = 5; sg2M = sgn;
    end else if (sft) begin
      if (cnt1M != 0) begin my1M = modelShift(my1M, sg1M, 1); cnt1M--; end
      if (cnt2M != 0) begin my2M = modelShift(my2M, sg2M, 2); cnt2M--; end
    end
    e.mx = mxM; e.my1 = my1M; e.cnt1 = cnt1M; e.my2 = my2M; e.cnt2 = cnt2M;
    scoreQ.push_back(e);
    @(posedge CLK);
    #1;
    if (scoreQ.size() == 0) begin
      checkOutput("queue_empty", 32'd0, 32'd1);
    end else begin
      compareAll(scoreQ.pop_front());
    end
    LOAD_MX = 1'b0; LOAD_MY = 1'b0; SFT_MY = 1'b0;
  endtask

  task automatic shiftOnce();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic loadMy(input logic [MY_W-1:0] v, input logic sgn);
    applyStimulus(1'b0, '0, 1'b1, v, sgn, 1'b0);
  endtask

  expect_t rstE;
  logic [0:0] seq1 [9];
  logic [1:0] seq2 [5];

  initial begin
    seq1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    seq2 = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
    rstE.mx = '0; rstE.my1 = '0; rstE.cnt1 = 0; rstE.my2 = '0; rstE.cnt2 = 0;

    RST_N = 1'b0;
    IN_MX = '0; IN_MY = '0;
    LOAD_MX = 1'b0; LOAD_MY = 1'b0; SFT_MY = 1'b0; SIGNED_MY = 1'b0;
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    compareAll(rstE);
    @(negedge CLK);
    RST_N = 1'b1;

    // Unsigned load of both operands in the same cycle.
    applyStimulus(1'b1, 16'hA5C3, 1'b1, 9'h1B5, 1'b0, 1'b0);
    checkOutput("tp_mx", 32'(mx1), 32'hA5C3);
    checkOutput("tp_my", 32'(my1), 32'h1B5);
    checkOutput("tp_cnt", 32'(cnt1), 32'd9);

    for (int i = 0; i < 9; i++) begin
      checkOutput("tp_digit_seq", 32'(dig1), 32'(seq1[i]));
      shiftOnce();
      if (i == 7) checkOutput("tp_last_after8", 32'(last1), 32'd1);
    end
    checkOutput("tp_done_after9", 32'(done1), 32'd1);
    checkOutput("tp_my_zero_after9", 32'(my1), 32'd0);
    shiftOnce();
    checkOutput("tp_no_wrap", 32'(cnt1), 32'd0);

    // Idle cycle: everything holds.
    applyStimulus(1'b0, 16'hFFFF, 1'b0, 9'h1FF, 1'b1, 1'b0);

    // Arithmetic versus logical shift of a negative multiplier.
    loadMy(9'h180, 1'b1);
    repeat (3) shiftOnce();
    checkOutput("tp_signed_my", 32'(my1), 32'h1F0);
    checkOutput("tp_signed_cnt", 32'(cnt1), 32'd6);
    checkOutput("tp_signed_zero", 32'(zero1), 32'd0);
    repeat (8) shiftOnce();
    checkOutput("tp_signed_saturate", 32'(my2), 32'h1FF);
    loadMy(9'h180, 1'b0);
    repeat (3) shiftOnce();
    checkOutput("tp_unsigned_my", 32'(my1), 32'h030);

    // Radix-4 digit sequence with an odd multiplier width.
    loadMy(9'h0E7, 1'b0);
    checkOutput("tp_r4_cnt", 32'(cnt2), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("tp_r4_digit_seq", 32'(dig2), 32'(seq2[i]));
      shiftOnce();
    end
    checkOutput("tp_r4_my", 32'(my2), 32'd0);
    checkOutput("tp_r4_done", 32'(done2), 32'd1);

    // Signed radix-4: the last digit's upper bit must be the sign.
    loadMy(9'h100, 1'b1);
    repeat (4) shiftOnce();
    checkOutput("tp_r4_sign_digit", 32'(dig2), 32'd3);

    // Load and shift together: the load wins.
    loadMy(9'h0E7, 1'b0);
    repeat (5) shiftOnce();
    checkOutput("tp_coll_pre_cnt", 32'(cnt1), 32'd4);
    applyStimulus(1'b0, '0, 1'b1, 9'h003, 1'b0, 1'b1);
    checkOutput("tp_coll_my", 32'(my1), 32'h003);
    checkOutput("tp_coll_cnt", 32'(cnt1), 32'd9);

    // Zero multiplier reached before all digits are consumed.
    loadMy(9'h004, 1'b0);
    repeat (3) shiftOnce();
    checkOutput("tp_early_zero", 32'(zero1), 32'd1);
    checkOutput("tp_early_cnt", 32'(cnt1), 32'd6);
    checkOutput("tp_early_done", 32'(done1), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    applyStimulus(1'b1, 16'h1234, 1'b1, 9'h0AA, 1'b1, 1'b0);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    modelReset();
    compareAll(rstE);
    @(negedge CLK);
    RST_N = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
